// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: memory-mapped I/O bridge between the processor data port,
// the dmem RAM and the game peripherals (output coordinates, PS2 key FIFO,
// free-running tick counter).
// Optional feature macro: MMIO_VSYNC_LATCH_EN (frame-synchronous output update).
module mmio_io_bridge #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int IO_BASE   = 2000,
  parameter int NUM_OUT   = 4,
  parameter int OUT_W     = 10,
  parameter int KEY_DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address_dmem,
  input  logic [DATA_W-1:0]        data,
  input  logic                     wren,
  input  logic                     rden,
  input  logic [DATA_W-1:0]        q_ram,
  output logic                     ram_wren,
  output logic [DATA_W-1:0]        q_dmem,
  input  logic                     ps2_key_pressed,
  input  logic [7:0]               ps2_key_data,
  input  logic                     frame_sync,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  output logic                     key_ready
);

  localparam int PTR_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A     = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(NUM_OUT);
  localparam logic [ADDR_W-1:0] OFF_KEY    = ADDR_W'(NUM_OUT + 1);
  localparam logic [ADDR_W-1:0] OFF_TICKS  = ADDR_W'(NUM_OUT + 2);

  // Address decode
  logic              w_is_io;
  logic [ADDR_W-1:0] w_off;
  logic              w_io_wr;
  logic              w_io_rd;

  assign w_is_io  = (address_dmem >= BASE_A);
  assign w_off    = address_dmem - BASE_A;
  assign w_io_wr  = wren & w_is_io;
  assign w_io_rd  = rden & w_is_io;
  assign ram_wren = wren & ~w_is_io;

  // Key FIFO state
  logic [7:0]       r_mem [KEY_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_kp_prev;
  logic [31:0]      r_ticks;
  logic             r_is_io_q;
  logic [DATA_W-1:0] r_io_rdata_q;

  logic w_empty, w_full, w_push_ev, w_pop, w_push, w_ovf_set, w_ovf_clr;
  logic [7:0]  w_head;
  logic [7:0]  w_cnt8;
  logic [15:0] w_status;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(KEY_DEPTH));
  assign w_push_ev = ps2_key_pressed & ~r_kp_prev;
  // A pop only happens on a real KEY_DATA load with something to return
  assign w_pop     = w_io_rd & (w_off == OFF_KEY) & ~w_empty;
  // When full, a same-cycle pop frees the slot the push lands in
  assign w_push    = w_push_ev & (~w_full | w_pop);
  assign w_ovf_set = w_push_ev & w_full & ~w_pop;
  assign w_ovf_clr = w_io_wr & (w_off == OFF_STATUS);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_cnt8    = 8'(r_count);
  assign w_status  = {w_cnt8, 6'b0, r_ovf, ~w_empty};
  assign key_ready = ~w_empty;

  // Output coordinate registers; w_view is what a processor read sees
  logic [NUM_OUT*OUT_W-1:0] w_view;

`ifdef MMIO_VSYNC_LATCH_EN
  logic r_fs_prev;
  logic w_fs_rise;
  logic w_unused;
  assign w_fs_rise = frame_sync & ~r_fs_prev;
  assign w_unused  = ^data;

  // Frame-sync edge detector
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_fs_prev <= 1'b0;
    else       r_fs_prev <= frame_sync;
  end
`else
  logic w_unused;
  assign w_unused = ^{frame_sync, data};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic             w_out_wr;
      logic [OUT_W-1:0] r_out;
      assign w_out_wr = w_io_wr & (w_off == ADDR_W'(gi));
      assign out_regs[gi*OUT_W +: OUT_W] = r_out;
`ifdef MMIO_VSYNC_LATCH_EN
      logic [OUT_W-1:0] r_shadow;
      assign w_view[gi*OUT_W +: OUT_W] = r_shadow;
      // Writes land in the shadow; the visible copy follows at a frame boundary
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_shadow <= '0;
          r_out    <= '0;
        end else begin
          if (w_out_wr)  r_shadow <= data[OUT_W-1:0];
          if (w_fs_rise) r_out    <= r_shadow;
        end
      end
`else
      assign w_view[gi*OUT_W +: OUT_W] = r_out;
      // Writes update the visible coordinate immediately
      always_ff @(posedge clock or posedge reset) begin
        if (reset)         r_out <= '0;
        else if (w_out_wr) r_out <= data[OUT_W-1:0];
      end
`endif
    end
  endgenerate

  // Key byte storage (no reset: contents are only meaningful via the pointers)
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= ps2_key_data;
  end

  // FIFO pointers, occupancy, sticky overflow and key edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_kp_prev <= 1'b0;
    end else begin
      r_kp_prev <= ps2_key_pressed;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
      else if (~w_push & w_pop) r_count <= r_count - 1'b1;
      // A new overflow outranks a same-cycle clear
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ticks <= '0;
    else       r_ticks <= r_ticks + 32'd1;
  end

  // I/O read mux, sampling pre-edge state of every register
  logic [DATA_W-1:0] w_io_rdata;
  always_comb begin
    w_io_rdata = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_off == ADDR_W'(i)) w_io_rdata = DATA_W'(w_view[i*OUT_W +: OUT_W]);
    end
    if (w_off == OFF_STATUS) w_io_rdata = DATA_W'(w_status);
    if (w_off == OFF_KEY)    w_io_rdata = w_empty ? '0 : DATA_W'(w_head);
    if (w_off == OFF_TICKS)  w_io_rdata = DATA_W'(r_ticks);
  end

  // One-cycle read pipeline to match the synchronous dmem
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_io_q    <= 1'b0;
      r_io_rdata_q <= '0;
    end else begin
      r_is_io_q    <= w_is_io;
      r_io_rdata_q <= w_io_rdata;
    end
  end

  assign q_dmem = r_is_io_q ? r_io_rdata_q : q_ram;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed, table-driven bench for mmio_io_bridge (default parameters).
module tb_mmio_io_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic        rden;
  logic [31:0] q_ram;
  logic        ram_wren;
  logic [31:0] q_dmem;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic        frame_sync;
  logic [39:0] out_regs;
  logic        key_ready;

  int checks = 0;
  int errors = 0;

  mmio_io_bridge dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .rden(rden), .q_ram(q_ram), .ram_wren(ram_wren),
    .q_dmem(q_dmem), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .frame_sync(frame_sync),
    .out_regs(out_regs), .key_ready(key_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] dat;
    logic        we;
    logic        re;
    logic        kp;
    logic [7:0]  kd;
    logic        fs;
    logic        exp_ramw;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_ready;
    logic [39:0] exp_out;
  } vec_t;

  localparam logic [39:0] OUT_AB = 40'h0_0002_AC00;  // 0x0AB in OUT[1]
`ifdef MMIO_VSYNC_LATCH_EN
  localparam logic [39:0] V1_OUT = 40'h0;
`else
  localparam logic [39:0] V1_OUT = OUT_AB;
`endif

  vec_t vecs [20];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic idle();
    address_dmem = 12'd0; data = 32'd0; wren = 1'b0; rden = 1'b0;
    ps2_key_pressed = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic rd_io(input logic [11:0] a, output logic [31:0] v);
    address_dmem = a; rden = 1'b1;
    @(negedge clock);
    v = q_dmem;
    rden = 1'b0; address_dmem = 12'd0;
  endtask

  task automatic wr_io(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0; address_dmem = 12'd0;
  endtask

  task automatic push_key(input logic [7:0] b);
    ps2_key_pressed = 1'b1; ps2_key_data = b;
    @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
  endtask

  function automatic vec_t mk(input logic [11:0] a, input logic [31:0] d,
                              input logic we, input logic re, input logic kp,
                              input logic [7:0] kd, input logic fs,
                              input logic ramw, input logic cq, input logic [31:0] q,
                              input logic rdy, input logic [39:0] o);
    vec_t v;
    v.addr = a; v.dat = d; v.we = we; v.re = re; v.kp = kp; v.kd = kd; v.fs = fs;
    v.exp_ramw = ramw; v.chk_q = cq; v.exp_q = q; v.exp_ready = rdy; v.exp_out = o;
    return v;
  endfunction

  logic [31:0] rv;

  initial begin
    q_ram = 32'hCAFE_F00D;
    ps2_key_data = 8'h00;
    idle();
    reset = 1'b1;

    //            addr   data         we re kp kd    fs ramw cq q             rdy out
    vecs[0]  = mk(12'd500,  32'h155,     1, 0, 0, 8'h00, 0, 1, 0, 32'h0,        0, 40'h0);
    vecs[1]  = mk(12'd2001, 32'h0AB,     1, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, V1_OUT);
    vecs[2]  = mk(12'd2001, 32'h0,       0, 1, 0, 8'h00, 1, 0, 1, 32'h0000_00AB, 0, OUT_AB);
    vecs[3]  = mk(12'd0,    32'h0,       0, 0, 1, 8'h1D, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[4]  = mk(12'd0,    32'h0,       0, 0, 0, 8'h1D, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[5]  = mk(12'd0,    32'h0,       0, 0, 1, 8'h1B, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[6]  = mk(12'd0,    32'h0,       0, 0, 0, 8'h1B, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[7]  = mk(12'd0,    32'h0,       0, 0, 1, 8'h23, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[8]  = mk(12'd0,    32'h0,       0, 0, 0, 8'h23, 0, 0, 0, 32'h0,        1, OUT_AB);
    vecs[9]  = mk(12'd2004, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0000_0301, 1, OUT_AB);
    vecs[10] = mk(12'd2005, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0000_001D, 1, OUT_AB);
    vecs[11] = mk(12'd2005, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0000_001B, 1, OUT_AB);
    vecs[12] = mk(12'd2005, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0000_0023, 0, OUT_AB);
    vecs[13] = mk(12'd2005, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0,        0, OUT_AB);
    vecs[14] = mk(12'd2004, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0,        0, OUT_AB);
    vecs[15] = mk(12'd2007, 32'hFFFFFFFF, 1, 0, 0, 8'h00, 0, 0, 0, 32'h0,        0, OUT_AB);
    vecs[16] = mk(12'd2007, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0,        0, OUT_AB);
    vecs[17] = mk(12'd500,  32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'hCAFE_F00D, 0, OUT_AB);
    vecs[18] = mk(12'd1999, 32'h5,       1, 0, 0, 8'h00, 0, 1, 0, 32'h0,        0, OUT_AB);
    vecs[19] = mk(12'd2000, 32'h0,       0, 1, 0, 8'h00, 0, 0, 1, 32'h0,        0, OUT_AB);

    // Reset state
    @(negedge clock);
    check("reset out_regs", 64'(out_regs), 64'h0);
    check("reset key_ready", 64'(key_ready), 64'h0);
    check("reset q_dmem follows q_ram", 64'(q_dmem), 64'hCAFE_F00D);
    reset = 1'b0;

    // Table: decode, OUT write/read, key FIFO ordering, unmapped, boundaries
    for (int i = 0; i < 20; i++) begin
      address_dmem = vecs[i].addr; data = vecs[i].dat; wren = vecs[i].we;
      rden = vecs[i].re; ps2_key_pressed = vecs[i].kp; ps2_key_data = vecs[i].kd;
      frame_sync = vecs[i].fs;
      #1;
      check($sformatf("v%0d ram_wren", i), 64'(ram_wren), 64'(vecs[i].exp_ramw));
      @(negedge clock);
      if (vecs[i].chk_q) check($sformatf("v%0d q_dmem", i), 64'(q_dmem), 64'(vecs[i].exp_q));
      check($sformatf("v%0d key_ready", i), 64'(key_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d out_regs", i), 64'(out_regs), 64'(vecs[i].exp_out));
    end
    idle();
    @(negedge clock);

    // Held key level pushes once
    ps2_key_pressed = 1'b1; ps2_key_data = 8'h1C;
    repeat (20) @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    rd_io(12'd2004, rv); check("held key status", 64'(rv), 64'h101);
    rd_io(12'd2005, rv); check("held key data", 64'(rv), 64'h1C);
    rd_io(12'd2004, rv); check("held key drained", 64'(rv), 64'h0);

    // Overflow: 9 pushes into depth 8
    for (int k = 0; k < 9; k++) push_key(8'(8'h40 + k));
    rd_io(12'd2004, rv); check("overflow status", 64'(rv), 64'h803);
    wr_io(12'd2004, 32'h0);
    rd_io(12'd2004, rv); check("overflow cleared", 64'(rv), 64'h801);
    // Overflow set and clear in the same cycle: set wins
    ps2_key_pressed = 1'b1; ps2_key_data = 8'h77;
    wr_io(12'd2004, 32'h0);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    rd_io(12'd2004, rv); check("set beats clear", 64'(rv), 64'h803);
    wr_io(12'd2004, 32'h0);
    rd_io(12'd2004, rv); check("overflow cleared again", 64'(rv), 64'h801);
    // Push and pop together while full
    ps2_key_pressed = 1'b1; ps2_key_data = 8'h88;
    rd_io(12'd2005, rv); check("full push+pop data", 64'(rv), 64'h40);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    rd_io(12'd2004, rv); check("full push+pop status", 64'(rv), 64'h801);
    for (int k = 0; k < 8; k++) begin
      rd_io(12'd2005, rv);
      check($sformatf("drain %0d", k), 64'(rv), (k < 7) ? 64'(8'h41 + k) : 64'h88);
    end
    // Push and pop together while empty
    ps2_key_pressed = 1'b1; ps2_key_data = 8'h99;
    rd_io(12'd2005, rv); check("empty push+pop data", 64'(rv), 64'h0);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    rd_io(12'd2004, rv); check("empty push+pop status", 64'(rv), 64'h101);

    // Asynchronous reset mid-burst
    wr_io(12'd2000, 32'h123);
    for (int k = 0; k < 5; k++) push_key(8'(8'h60 + k));
    check("pre-reset key_ready", 64'(key_ready), 64'h1);
    #2 reset = 1'b1;
    #1;
    check("async reset out_regs", 64'(out_regs), 64'h0);
    check("async reset key_ready", 64'(key_ready), 64'h0);
    check("async reset q_dmem", 64'(q_dmem), 64'hCAFE_F00D);
    @(negedge clock);
    reset = 1'b0;
    address_dmem = 12'd2006; rden = 1'b1;
    @(negedge clock);
    check("ticks after reset", 64'(q_dmem), 64'h0);
    @(negedge clock);
    check("ticks increments", 64'(q_dmem), 64'h1);
    idle();
    rd_io(12'd2004, rv); check("status after reset", 64'(rv), 64'h0);
    rd_io(12'd2000, rv); check("OUT0 after reset", 64'(rv), 64'h0);

    // OUT[0] update timing
    wr_io(12'd2000, 32'h3FF);
`ifdef MMIO_VSYNC_LATCH_EN
    repeat (3) @(negedge clock);
    check("shadowed OUT0 not visible", 64'(out_regs[9:0]), 64'h0);
    frame_sync = 1'b1;
    @(negedge clock);
    frame_sync = 1'b0;
    check("OUT0 after frame_sync", 64'(out_regs[9:0]), 64'h3FF);
`else
    check("OUT0 after write", 64'(out_regs[9:0]), 64'h3FF);
    frame_sync = 1'b1;
    @(negedge clock);
    frame_sync = 1'b0;
    check("OUT0 stable across frame_sync", 64'(out_regs[9:0]), 64'h3FF);
`endif
    rd_io(12'd2000, rv); check("OUT0 readback", 64'(rv), 64'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
